// File: rtl/stopwatch_lap_timer.sv
// rtl/stopwatch_lap_timer.sv - BCD stopwatch with lap freeze and multiplexed seven-segment drive
//
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (k >= 2).
//
// Ports:
//   clk_100_Mhz                in   system clock
//   reset_n                    in   asynchronous active-low reset
//   start_stop                 in   pulse, toggles run/stop
//   clear                      in   pulse, zeroes time (only while stopped)
//   lap                        in   pulse, toggles display freeze
//   running                    out  high while counting
//   lap_active                 out  high while display is frozen
//   overflow                   out  sticky full-scale wrap flag
//   count_bcd                  out  live BCD count, digit k at [4k+3:4k]
//   anode_bits                 out  active-low digit strobes, bit 0 rightmost
//   seven_segments_LED_output  out  active-low segments a..g (MSB..LSB)
//   decimal_point              out  active-low decimal point
module stopwatch_lap_timer #(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int TICK_HZ      = 10,
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 17
) (
    input  logic                      clk_100_Mhz,
    input  logic                      reset_n,
    input  logic                      start_stop,
    input  logic                      clear,
    input  logic                      lap,
    output logic                      running,
    output logic                      lap_active,
    output logic                      overflow,
    output logic [4*NUM_DIGITS-1:0]   count_bcd,
    output logic [NUM_DIGITS-1:0]     anode_bits,
    output logic [6:0]                seven_segments_LED_output,
    output logic                      decimal_point
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CW    = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0]        tick_cnt;
    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [CW-1:0]           lap_latch;
    logic [CW-1:0]           count_next;
    logic [CW-1:0]           shown;
    logic [3:0]              digit;
    logic                    tick;
    logic                    clear_ok;
    logic                    wrap;
    logic                    carry;
    int                      idx;

    // Tens-of-seconds digit is base 6; every other digit is decimal.
    function automatic logic [3:0] digit_max(input int k);
        return (k == 2) ? 4'd5 : 4'd9;
    endfunction

    assign tick     = running && (tick_cnt == DIV_W'(DIV - 1));
    assign clear_ok = clear && !running;

    // Ripple carry through the mixed-radix digits in a single cycle.
    always_comb begin
        count_next = count_bcd;
        carry      = tick;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (count_bcd[4*k +: 4] == digit_max(k)) begin
                    count_next[4*k +: 4] = 4'd0;
                end else begin
                    count_next[4*k +: 4] = count_bcd[4*k +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    always_ff @(posedge clk_100_Mhz or negedge reset_n) begin
        if (!reset_n) begin
            running    <= 1'b0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
            count_bcd  <= '0;
            lap_latch  <= '0;
            tick_cnt   <= '0;
        end else begin
            if (start_stop) begin
                running <= !running;
            end
            if (clear_ok) begin
                // Clear only happens while stopped, so no lap toggle can collide.
                tick_cnt   <= '0;
                count_bcd  <= '0;
                overflow   <= 1'b0;
                lap_active <= 1'b0;
            end else begin
                // Prescaler holds while stopped so a resume keeps the partial tick.
                if (running) begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                end
                count_bcd <= count_next;
                if (wrap) begin
                    overflow <= 1'b1;
                end
                if (lap) begin
                    if (running) begin
                        lap_active <= !lap_active;
                        if (!lap_active) begin
                            lap_latch <= count_bcd;   // pre-tick value
                        end
                    end else begin
                        lap_active <= 1'b0;           // stopped: release only
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_100_Mhz or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) begin
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end
        end
    end

    always_comb begin
        shown      = lap_active ? lap_latch : count_bcd;
        idx        = int'(scan_idx);
        digit      = shown[4*idx +: 4];
        anode_bits = ~(ONE_HOT0 << scan_idx);
        decimal_point = ((idx == 1) || (idx == 3)) ? 1'b0 : 1'b1;
        case (digit)
            4'd0:    seven_segments_LED_output = 7'b0000001;
            4'd1:    seven_segments_LED_output = 7'b1001111;
            4'd2:    seven_segments_LED_output = 7'b0010010;
            4'd3:    seven_segments_LED_output = 7'b0000110;
            4'd4:    seven_segments_LED_output = 7'b1001100;
            4'd5:    seven_segments_LED_output = 7'b0100100;
            4'd6:    seven_segments_LED_output = 7'b0100000;
            4'd7:    seven_segments_LED_output = 7'b0001111;
            4'd8:    seven_segments_LED_output = 7'b0000000;
            4'd9:    seven_segments_LED_output = 7'b0000100;
            default: seven_segments_LED_output = 7'b0000001;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // Digit k and everything above it zero: blank, anode keeps strobing.
        if ((idx >= 2) && ((shown >> (4*idx)) == '0)) begin
            seven_segments_LED_output = 7'b1111111;
            decimal_point             = 1'b1;
        end
`else
`endif
    end

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb/tb_stopwatch_lap_timer.sv - scoreboard testbench for stopwatch_lap_timer
module tb_stopwatch_lap_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic        f_start = 1'b0, f_clear = 1'b0, f_lap = 1'b0;

    logic        running, lap_active, overflow;
    logic [15:0] count_bcd;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    logic        f_running, f_lap_active, f_overflow;
    logic [15:0] f_count;
    logic [3:0]  f_anode;
    logic [6:0]  f_seg;
    logic        f_dp;

    always #5 clk = ~clk;

    stopwatch_lap_timer #(.CLK_FREQ_HZ(100), .TICK_HZ(10), .NUM_DIGITS(4), .REFRESH_BITS(2)) dut (
        .clk_100_Mhz(clk), .reset_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
        .running(running), .lap_active(lap_active), .overflow(overflow), .count_bcd(count_bcd),
        .anode_bits(anode), .seven_segments_LED_output(seg), .decimal_point(dp));

    // Second instance with DIV=2 to reach full scale in a short run.
    stopwatch_lap_timer #(.CLK_FREQ_HZ(20), .TICK_HZ(10), .NUM_DIGITS(4), .REFRESH_BITS(2)) fast (
        .clk_100_Mhz(clk), .reset_n(rst_n), .start_stop(f_start), .clear(f_clear), .lap(f_lap),
        .running(f_running), .lap_active(f_lap_active), .overflow(f_overflow), .count_bcd(f_count),
        .anode_bits(f_anode), .seven_segments_LED_output(f_seg), .decimal_point(f_dp));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] act);
        exp_t e;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, act, e.val);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic c, input logic l, input logic fs, input logic fc);
        start_stop = s; clear = c; lap = l; f_start = fs; f_clear = fc;
        @(negedge clk);
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0; f_start = 1'b0; f_clear = 1'b0;
    endtask

    task automatic read_slot(input int k, output logic [6:0] s, output logic d);
        logic [3:0] one;
        logic [3:0] want;
        int         n;
        one  = 4'b0001;
        want = ~(one << k);
        n    = 0;
        while (anode !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("slot_found", 32'(anode), 32'(want));
        s = seg;
        d = dp;
    endtask

    logic [3:0] an_exp [4];
    logic       dp_exp [4];
    logic [6:0] s;
    logic       d;
    int         n;

    initial begin
        an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        dp_exp = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        clks(2);
        expect_val("rst_running", 0);         observe(32'(running));
        expect_val("rst_lap", 0);             observe(32'(lap_active));
        expect_val("rst_ovf", 0);             observe(32'(overflow));
        expect_val("rst_count", 0);           observe(32'(count_bcd));
        expect_val("rst_anode", 4'b1110);     observe(32'(anode));
        expect_val("rst_seg", 7'b0000001);    observe(32'(seg));
        expect_val("rst_dp", 1);              observe(32'(dp));
        rst_n = 1'b1;

        // Scan order and dwell: align to the first clock of the digit-0 slot.
        n = 0;
        while (anode === 4'b1110 && n < 64) begin @(negedge clk); n++; end
        while (anode !== 4'b1110 && n < 64) begin @(negedge clk); n++; end
        chk("scan_align", 32'(anode), 32'(4'b1110));
        for (int i = 0; i < 16; i++) begin
            expect_val("scan_anode", 32'(an_exp[i/4]));  observe(32'(anode));
            expect_val("scan_dp", 32'(dp_exp[i/4]));     observe(32'(dp));
            expect_val("scan_seg", 7'b0000001);          observe(32'(seg));
            @(negedge clk);
        end

        // Start, first tick after DIV clocks.
        pulse(1, 0, 0, 0, 0);
        expect_val("run_on", 1);            observe(32'(running));
        clks(9);
        expect_val("pre_tick", 16'h0000);   observe(32'(count_bcd));
        clks(1);
        expect_val("tick1", 16'h0001);      observe(32'(count_bcd));
        clks(90);
        expect_val("tick10", 16'h0010);     observe(32'(count_bcd));

        // Stop at 2.3 with prescaler holding 4.
        clks(133);
        pulse(1, 0, 0, 0, 0);
        expect_val("stop_cnt", 16'h0023);   observe(32'(count_bcd));
        expect_val("stop_run", 0);          observe(32'(running));
        clks(50);
        expect_val("held_cnt", 16'h0023);   observe(32'(count_bcd));
        pulse(1, 0, 0, 0, 0);
        expect_val("resume_run", 1);        observe(32'(running));
        clks(5);
        expect_val("resume_5", 16'h0023);   observe(32'(count_bcd));
        clks(1);
        expect_val("resume_6", 16'h0024);   observe(32'(count_bcd));
        pulse(0, 1, 0, 0, 0);
        expect_val("clr_ign_cnt", 16'h0024); observe(32'(count_bcd));
        expect_val("clr_ign_run", 1);       observe(32'(running));
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        expect_val("clr_cnt", 16'h0000);    observe(32'(count_bcd));
        expect_val("clr_ovf", 0);           observe(32'(overflow));
        expect_val("clr_run", 0);           observe(32'(running));

        // Show 0.7 and inspect the two right-hand slots.
        pulse(1, 0, 0, 0, 0);
        clks(70);
        pulse(1, 0, 0, 0, 0);
        expect_val("cnt7", 16'h0007);       observe(32'(count_bcd));
        read_slot(0, s, d);
        expect_val("seg7", 7'b0001111);     observe(32'(s));
        expect_val("dp_slot0", 1);          observe(32'(d));
        read_slot(1, s, d);
        expect_val("seg_slot1", 7'b0000001); observe(32'(s));
        expect_val("dp_slot1", 0);          observe(32'(d));
        pulse(0, 1, 0, 0, 0);

        // Lap freeze at 1.2 while the live count advances to 2.0.
        pulse(1, 0, 0, 0, 0);
        clks(120);
        expect_val("lap_pre", 16'h0012);    observe(32'(count_bcd));
        pulse(0, 0, 1, 0, 0);
        expect_val("lap_on", 1);            observe(32'(lap_active));
        clks(79);
        expect_val("lap_live", 16'h0020);   observe(32'(count_bcd));
        read_slot(0, s, d);
        expect_val("frz_d0", 7'b0010010);   observe(32'(s));
        read_slot(1, s, d);
        expect_val("frz_d1", 7'b1001111);   observe(32'(s));
        pulse(0, 0, 1, 0, 0);
        expect_val("lap_off", 0);           observe(32'(lap_active));
        read_slot(1, s, d);
        expect_val("live_d1", 7'b0010010);  observe(32'(s));
        pulse(0, 0, 1, 0, 0);
        pulse(1, 0, 0, 0, 0);
        expect_val("stop_lap_run", 0);      observe(32'(running));
        expect_val("stop_lap_act", 1);      observe(32'(lap_active));
        pulse(0, 0, 1, 0, 0);
        expect_val("stop_lap_rel", 0);      observe(32'(lap_active));

        // Full-scale behaviour on the DIV=2 instance.
        pulse(0, 0, 0, 1, 0);
        expect_val("f_run", 1);             observe(32'(f_running));
        clks(1198);
        expect_val("f_599", 16'h0599);      observe(32'(f_count));
        clks(2);
        expect_val("f_1000", 16'h1000);     observe(32'(f_count));
        clks(10799);
        expect_val("f_9599", 16'h9599);     observe(32'(f_count));
        expect_val("f_ovf0", 0);            observe(32'(f_overflow));
        clks(1);
        expect_val("f_wrap", 16'h0000);     observe(32'(f_count));
        expect_val("f_ovf1", 1);            observe(32'(f_overflow));
        expect_val("f_still_run", 1);       observe(32'(f_running));
        clks(2);
        expect_val("f_after", 16'h0001);    observe(32'(f_count));
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 1, 1);
        expect_val("f_cs_cnt", 16'h0000);   observe(32'(f_count));
        expect_val("f_cs_ovf", 0);          observe(32'(f_overflow));
        expect_val("f_cs_run", 1);          observe(32'(f_running));
        clks(1);
        expect_val("f_cs_1", 16'h0000);     observe(32'(f_count));
        clks(1);
        expect_val("f_cs_2", 16'h0001);     observe(32'(f_count));

        // Asynchronous reset between clock edges.
        pulse(1, 0, 0, 0, 0);
        clks(25);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        expect_val("ar_running", 0);        observe(32'(running));
        expect_val("ar_lap", 0);            observe(32'(lap_active));
        expect_val("ar_ovf", 0);            observe(32'(overflow));
        expect_val("ar_count", 0);          observe(32'(count_bcd));
        expect_val("ar_anode", 4'b1110);    observe(32'(anode));
        expect_val("ar_seg", 7'b0000001);   observe(32'(seg));
        expect_val("ar_dp", 1);             observe(32'(dp));
        @(negedge clk);
        rst_n = 1'b1;
        clks(2);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
